// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the two-requester arbiter
package arb_pkg;
  localparam int N_REQ = 2;
  typedef logic [N_REQ-1:0] req_vec_t;
  localparam int unsigned DEFAULT_MAX_HOLD = 4;

  function automatic req_vec_t onehot(input logic idx);
    req_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/modport_arbiter_if.sv
// rtl/modport_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface modport_arbiter_if;
  import arb_pkg::*;

  req_vec_t request;
  req_vec_t grant;

  modport master (output request, input grant);
  modport slave  (input request, output grant);
endinterface

// File: rtl/arb_hold_cnt.sv
// rtl/arb_hold_cnt.sv - saturating tenure counter with limit-reached flag
module arb_hold_cnt #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load1,
  input  logic inc,
  output logic at_limit
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A zero limit means tenure is unbounded, so the flag never fires.
  generate
    if (MAX_HOLD == 0) begin : g_unlimited
      assign at_limit = 1'b0;
    end else begin : g_limited
      assign at_limit = (cnt >= CNT_W'(MAX_HOLD));
    end
  endgenerate
endmodule

// File: rtl/modport_arbiter.sv
// rtl/modport_arbiter.sv - round-robin arbiter with grant hold and bounded tenure
module modport_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  modport_arbiter_if.slave    arb
);
  req_vec_t grant_q, grant_n;
  logic     last_q, last_n;
  logic     clr, load1, inc, at_limit, win;
  req_vec_t req;

  arb_hold_cnt #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .load1    (load1),
    .inc      (inc),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_q <= '0;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_n;
      last_q  <= last_n;
    end
  end

  always_comb begin
    grant_n = grant_q;
    last_n  = last_q;
    clr     = 1'b0;
    load1   = 1'b0;
    inc     = 1'b0;
    win     = 1'b0;
    req     = arb.request;
    if (req == '0) begin
      grant_n = '0;
      clr     = 1'b1;
    end else if ((|(grant_q & req)) && (((req & ~grant_q) == '0) || !at_limit)) begin
      inc = 1'b1;
    end else begin
      // Under contention the side that did not win last time takes it.
      win     = (req == 2'b11) ? ~last_q : req[1];
      grant_n = onehot(win);
      last_n  = win;
      load1   = 1'b1;
    end
  end

  assign arb.grant = grant_q;
endmodule

// File: tb/tb_modport_arbiter.sv
// tb/tb_modport_arbiter.sv - self-checking bench for modport_arbiter (limited and unlimited hold)
module tb_modport_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  modport_arbiter_if if0();
  modport_arbiter_if if1();

  modport_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut0 (.clk(clk), .reset(reset), .arb(if0));
  modport_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .arb(if1));

  // Reference model: owner index (-1 idle), last winner, tenure cycles.
  int owner[2];
  int last_w[2];
  int tenure[2];
  int mh[2] = '{4, 0};

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [1:0] model_grant(input int o);
    if (o < 0) return 2'b00;
    return (o == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_step(input int d, input logic rst, input logic [1:0] rq);
    int w;
    if (!rst) begin
      owner[d] = -1; last_w[d] = 1; tenure[d] = 0;
    end else if (rq == 2'b00) begin
      owner[d] = -1; tenure[d] = 0;
    end else if (owner[d] >= 0 && rq[owner[d]] &&
                 (!rq[1-owner[d]] || mh[d] == 0 || tenure[d] < mh[d])) begin
      if (tenure[d] < 255) tenure[d] = tenure[d] + 1;
    end else begin
      if (rq == 2'b11) w = 1 - last_w[d];
      else w = rq[0] ? 0 : 1;
      owner[d] = w; last_w[d] = w; tenure[d] = 1;
    end
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: grant=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at edge+2: drive, wait for edge, advance model, compare at edge+1.
  task automatic step(input logic rst, input logic [1:0] rq);
    reset = rst;
    if0.request = rq;
    if1.request = rq;
    @(posedge clk);
    model_step(0, rst, rq);
    model_step(1, rst, rq);
    #1;
    check("model_hold4", if0.grant, model_grant(owner[0]));
    check("model_hold0", if1.grant, model_grant(owner[1]));
    #1;
  endtask

  task automatic add(input logic rst, input logic [1:0] rq, input logic [1:0] exp, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = rst; v.req = rq; v.exp = exp;
      vecs.push_back(v);
    end
  endtask

  initial begin
    if0.request = 2'b00;
    if1.request = 2'b00;
    owner = '{-1, -1}; last_w = '{1, 1}; tenure = '{0, 0};
    @(posedge clk);
    #2;

    add(0, 2'b11, 2'b00, 2);
    add(1, 2'b00, 2'b00, 1);
    add(1, 2'b01, 2'b01, 1);
    add(1, 2'b00, 2'b00, 1);
    add(1, 2'b10, 2'b10, 1);
    add(1, 2'b00, 2'b00, 1);
    add(1, 2'b11, 2'b01, 4);
    add(1, 2'b11, 2'b10, 4);
    add(1, 2'b11, 2'b01, 4);
    add(1, 2'b11, 2'b10, 4);
    add(1, 2'b00, 2'b00, 1);
    add(1, 2'b11, 2'b01, 2);
    add(1, 2'b10, 2'b10, 1);
    add(1, 2'b11, 2'b10, 3);
    add(1, 2'b11, 2'b01, 4);
    add(1, 2'b11, 2'b10, 2);
    add(0, 2'b11, 2'b00, 1);
    add(1, 2'b11, 2'b01, 1);
    add(1, 2'b00, 2'b00, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i), if0.grant, vecs[i].exp);
    end

    step(0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      step(1, 2'b11);
      check("unlimited_hold", if1.grant, 2'b01);
    end
    step(1, 2'b10);
    check("unlimited_drop", if1.grant, 2'b10);
    step(1, 2'b11);
    check("unlimited_keep1", if1.grant, 2'b10);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) != 0), 2'($urandom_range(0, 3)));
      checks++;
      if (if0.grant == 2'b11 || if1.grant == 2'b11) begin
        errors++;
        $display("FAIL onehot: grant0=%b grant1=%b expected not 11", if0.grant, if1.grant);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
